// File: rtl/peripheral_uart_wb_driver.sv
// rtl/peripheral_uart_wb_driver.sv - Wishbone initiator that configures and services a 16550-style UART
//
// After reset, the driver writes the UART configuration registers:
//   LCR = 0x83        (open the divisor latch)
//   DLL / DLM         (baud divisor)
//   LCR               (final line control, DLAB cleared)
//   FCR               (FIFO control)
// It then polls LSR forever. A received byte (LSR[0]) is moved into a
// one-deep RX holding register. A pending TX byte is written to THR when
// LSR[5] reports the holding register empty.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   wb_adr_o[2:0]           register address
//   wb_dat_o[7:0]           write data
//   wb_dat_i[7:0]           read data
//   wb_we_o                 write enable
//   wb_stb_o, wb_cyc_o      strobe, cycle
//   wb_sel_o[3:0]           byte select (4'b0001 while strobing)
//   wb_ack_i                acknowledge
//   tx_valid_i, tx_data_i   TX byte stream in
//   tx_ready_o              TX stream ready
//   rx_valid_o, rx_data_o   RX byte stream out
//   rx_ready_i              RX stream ready
//   init_done_o             configuration finished (sticky)
//   err_o                   one-cycle pulse on an access timeout
module peripheral_uart_wb_driver #(
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter logic [7:0]  LCR_VALUE = 8'h03,
  parameter logic [7:0]  FCR_VALUE = 8'h07,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  output logic [3:0] wb_sel_o,
  input  logic       wb_ack_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  input  logic       rx_ready_i,
  output logic       init_done_o,
  output logic       err_o
);

  // Last value of the per-access wait counter before the access is abandoned.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  localparam logic [2:0] ADR_DATA = 3'd0;
  localparam logic [2:0] ADR_LSR  = 3'd5;

  // Each bus access is split into an issue state (strobe raised on exit)
  // and a wait state (strobe high until ack or timeout).
  typedef enum logic [3:0] {
    S_INIT,
    S_INIT_WAIT,
    S_POLL,
    S_POLL_WAIT,
    S_DECIDE,
    S_RX,
    S_RX_WAIT,
    S_TX,
    S_TX_WAIT
  } state_t;

  state_t      state, state_n;
  logic [2:0]  step, step_n;
  logic [15:0] cnt, cnt_n;
  logic        cyc, cyc_n;
  logic        stb, stb_n;
  logic        we, we_n;
  logic [2:0]  adr, adr_n;
  logic [7:0]  dat, dat_n;
  logic        err, err_n;
  logic        init_done, init_done_n;
  logic        tx_full, tx_full_n;
  logic [7:0]  tx_byte, tx_byte_n;
  logic        rx_full, rx_full_n;
  logic [7:0]  rx_byte, rx_byte_n;
  logic        lsr_dr, lsr_dr_n;
  logic        lsr_thre, lsr_thre_n;

  logic        ack_seen;
  logic        expired;
  logic        done;

  // Ack only counts while we are strobing; stray acks are ignored.
  assign ack_seen = stb && wb_ack_i;
  assign expired  = stb && !wb_ack_i && (cnt == TO_LAST);
  assign done     = ack_seen || expired;

  assign wb_cyc_o    = cyc;
  assign wb_stb_o    = stb;
  assign wb_we_o     = we;
  assign wb_adr_o    = adr;
  assign wb_dat_o    = dat;
  assign wb_sel_o    = stb ? 4'b0001 : 4'b0000;
  assign err_o       = err;
  assign init_done_o = init_done;
  assign tx_ready_o  = init_done && !tx_full;
  assign rx_valid_o  = rx_full;
  assign rx_data_o   = rx_byte;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_INIT;
      step      <= 3'd0;
      cnt       <= 16'd0;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      we        <= 1'b0;
      adr       <= 3'd0;
      dat       <= 8'h00;
      err       <= 1'b0;
      init_done <= 1'b0;
      tx_full   <= 1'b0;
      tx_byte   <= 8'h00;
      rx_full   <= 1'b0;
      rx_byte   <= 8'h00;
      lsr_dr    <= 1'b0;
      lsr_thre  <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      cnt       <= cnt_n;
      cyc       <= cyc_n;
      stb       <= stb_n;
      we        <= we_n;
      adr       <= adr_n;
      dat       <= dat_n;
      err       <= err_n;
      init_done <= init_done_n;
      tx_full   <= tx_full_n;
      tx_byte   <= tx_byte_n;
      rx_full   <= rx_full_n;
      rx_byte   <= rx_byte_n;
      lsr_dr    <= lsr_dr_n;
      lsr_thre  <= lsr_thre_n;
    end
  end

  always_comb begin
    state_n     = state;
    step_n      = step;
    cnt_n       = cnt;
    cyc_n       = cyc;
    stb_n       = stb;
    we_n        = we;
    adr_n       = adr;
    dat_n       = dat;
    err_n       = 1'b0;
    init_done_n = init_done;
    tx_full_n   = tx_full;
    tx_byte_n   = tx_byte;
    rx_full_n   = rx_full;
    rx_byte_n   = rx_byte;
    lsr_dr_n    = lsr_dr;
    lsr_thre_n  = lsr_thre;

    // Bus termination shared by all wait states: on ack or timeout the
    // whole request is cleared on the same edge.
    if (done) begin
      cyc_n = 1'b0;
      stb_n = 1'b0;
      we_n  = 1'b0;
      adr_n = 3'd0;
      dat_n = 8'h00;
      err_n = expired;
    end else if (stb) begin
      cnt_n = cnt + 16'd1;
    end

    // Stream handshakes. A fill never coincides with the THR write that
    // empties the register, since tx_ready_o is low while full.
    if (tx_valid_i && init_done && !tx_full) begin
      tx_full_n = 1'b1;
      tx_byte_n = tx_data_i;
    end
    if (rx_full && rx_ready_i) begin
      rx_full_n = 1'b0;
    end

    case (state)
      S_INIT: begin
        cyc_n   = 1'b1;
        stb_n   = 1'b1;
        we_n    = 1'b1;
        cnt_n   = 16'd0;
        state_n = S_INIT_WAIT;
        case (step)
          3'd0:    begin adr_n = 3'd3; dat_n = 8'h83;                   end
          3'd1:    begin adr_n = 3'd0; dat_n = DIVISOR[7:0];            end
          3'd2:    begin adr_n = 3'd1; dat_n = DIVISOR[15:8];           end
          3'd3:    begin adr_n = 3'd3; dat_n = LCR_VALUE & 8'h7F;       end
          default: begin adr_n = 3'd2; dat_n = FCR_VALUE;               end
        endcase
      end
      S_INIT_WAIT: begin
        // A timed-out init write is simply skipped.
        if (done) begin
          if (step == 3'd4) begin
            init_done_n = 1'b1;
            state_n     = S_POLL;
          end else begin
            step_n  = step + 3'd1;
            state_n = S_INIT;
          end
        end
      end
      S_POLL: begin
        cyc_n   = 1'b1;
        stb_n   = 1'b1;
        we_n    = 1'b0;
        adr_n   = ADR_LSR;
        dat_n   = 8'h00;
        cnt_n   = 16'd0;
        state_n = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        // A timed-out LSR read behaves as LSR = 0.
        if (done) begin
          lsr_dr_n   = ack_seen && wb_dat_i[0];
          lsr_thre_n = ack_seen && wb_dat_i[5];
          state_n    = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (lsr_dr && !rx_full) begin
          state_n = S_RX;
        end else if (lsr_thre && tx_full) begin
          state_n = S_TX;
        end else begin
          state_n = S_POLL;
        end
      end
      S_RX: begin
        cyc_n   = 1'b1;
        stb_n   = 1'b1;
        we_n    = 1'b0;
        adr_n   = ADR_DATA;
        dat_n   = 8'h00;
        cnt_n   = 16'd0;
        state_n = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        if (done) begin
          if (ack_seen) begin
            rx_full_n = 1'b1;
            rx_byte_n = wb_dat_i;
          end
          state_n = S_POLL;
        end
      end
      S_TX: begin
        cyc_n   = 1'b1;
        stb_n   = 1'b1;
        we_n    = 1'b1;
        adr_n   = ADR_DATA;
        dat_n   = tx_byte;
        cnt_n   = 16'd0;
        state_n = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        // The byte is released even on timeout so the stream never stalls.
        if (done) begin
          tx_full_n = 1'b0;
          state_n   = S_POLL;
        end
      end
      default: begin
        state_n = S_INIT;
      end
    endcase
  end

endmodule
